vending_machine_multi: RTL and testbench

//  Parametrised multi-product vending controller, successor of the fixed 20-unit machine.

---
 rtl/vending_machine_multi_pkg.sv | 20 ++
 rtl/vending_machine_multi_change_picker.sv | 37 +++
 rtl/vending_machine_multi.sv | 179 +++++++++++++++++
 tb/tb_vending_machine_multi.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vending_machine_multi_pkg.sv
// Shared definitions for the multi-product vending controller family.
//   - 2-bit coin codes used on the coin-in and coin-return interfaces
//   - FSM state encoding used by the controller top level
package vending_machine_multi_pkg;

  // Coin codes: 00 means "no coin" on both the acceptor and the hopper side.
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_A    = 2'b01;
  localparam logic [1:0] CODE_B    = 2'b10;
  localparam logic [1:0] CODE_C    = 2'b11;

  // IDLE holds zero credit, COLLECT holds non-zero credit.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_e;

endpackage

// File: rtl/vending_machine_multi_change_picker.sv
// vm_change_picker: combinational change selector.
//   credit_i : remaining credit to pay back
//   code_o   : code of the largest coin whose value is <= credit_i (CODE_NONE if none fits)
//   value_o  : value of that coin in money units (0 when code_o is CODE_NONE)
module vm_change_picker
  import vending_machine_multi_pkg::*;
#(
  parameter int CRED_W = 8,
  parameter int COIN_A = 5,
  parameter int COIN_B = 10,
  parameter int COIN_C = 25
) (
  input  logic [CRED_W-1:0] credit_i,
  output logic [1:0]        code_o,
  output logic [CRED_W-1:0] value_o
);

  // Largest-first greedy pick over the three coin denominations.
  always_comb begin
    code_o  = CODE_NONE;
    value_o = {CRED_W{1'b0}};
    if (credit_i >= CRED_W'(COIN_C)) begin
      code_o  = CODE_C;
      value_o = CRED_W'(COIN_C);
    end else if (credit_i >= CRED_W'(COIN_B)) begin
      code_o  = CODE_B;
      value_o = CRED_W'(COIN_B);
    end else if (credit_i >= CRED_W'(COIN_A)) begin
      code_o  = CODE_A;
      value_o = CRED_W'(COIN_A);
    end else begin
      code_o  = CODE_NONE;
      value_o = {CRED_W{1'b0}};
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: parametrised multi-product vending controller.
// Accepts coded coins into a saturating credit, vends the selected product when the
// credit covers its price, and pays back change or a cancel refund one coin per cycle,
// largest coin first.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in                  : coin code (00 none, 01 COIN_A, 10 COIN_B, 11 COIN_C)
//   sel, sel_valid      : product index and one-cycle request strobe
//   cancel              : one-cycle refund request (honoured only while collecting)
//   bottle, prod_id     : one-cycle vend pulse and the product being vended
//   change              : coin code returned this cycle (00 = none)
//   coin_reject         : pulse, the coin offered in the previous cycle was not taken
//   busy                : high while vending or paying back change
//   credit              : current credit
// All outputs come straight from flops.
module vending_machine_multi
  import vending_machine_multi_pkg::*;
#(
  parameter int                             NUM_PROD   = 4,
  parameter int                             CRED_W     = 8,
  parameter logic [NUM_PROD*CRED_W-1:0]     PRICE_LIST = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                             COIN_A     = 5,
  parameter int                             COIN_B     = 10,
  parameter int                             COIN_C     = 25,
  parameter int                             MAX_CREDIT = 100,
  localparam int                            SEL_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_valid,
  input  logic              cancel,
  output logic              bottle,
  output logic [SEL_W-1:0]  prod_id,
  output logic [1:0]        change,
  output logic              coin_reject,
  output logic              busy,
  output logic [CRED_W-1:0] credit
);

  // Configuration sanity: every amount must be a multiple of the smallest coin so the
  // greedy payback always lands exactly on zero.
  if (MAX_CREDIT >= (1 << CRED_W) || (MAX_CREDIT % COIN_A) != 0 ||
      (COIN_B % COIN_A) != 0 || (COIN_C % COIN_A) != 0) begin : g_bad_cfg
    $error("vending_machine_multi: MAX_CREDIT or coin values inconsistent with COIN_A/CRED_W");
  end
  for (genvar p = 0; p < NUM_PROD; p++) begin : g_price_chk
    if ((int'(PRICE_LIST[p*CRED_W +: CRED_W]) % COIN_A) != 0) begin : g_bad_price
      $error("vending_machine_multi: price is not a multiple of COIN_A");
    end
  end

  state_e             state_q, state_d;
  logic [CRED_W-1:0]  credit_q, credit_d;
  logic               bottle_q, bottle_d;
  logic [SEL_W-1:0]   prod_id_q, prod_id_d;
  logic [1:0]         change_q, change_d;
  logic               coin_reject_q, coin_reject_d;
  logic               busy_q, busy_d;

  logic [CRED_W-1:0]  coin_val_s;
  logic [CRED_W:0]    sum_s;
  logic [CRED_W-1:0]  price_s;
  logic               sel_ok_s;
  logic [1:0]         pick_code_s;
  logic [CRED_W-1:0]  pick_val_s;

  vm_change_picker #(
    .CRED_W (CRED_W),
    .COIN_A (COIN_A),
    .COIN_B (COIN_B),
    .COIN_C (COIN_C)
  ) u_picker (
    .credit_i (credit_q),
    .code_o   (pick_code_s),
    .value_o  (pick_val_s)
  );

  // Coin value decode and price lookup for the requested product.
  always_comb begin
    coin_val_s = {CRED_W{1'b0}};
    case (in)
      CODE_A:  coin_val_s = CRED_W'(COIN_A);
      CODE_B:  coin_val_s = CRED_W'(COIN_B);
      CODE_C:  coin_val_s = CRED_W'(COIN_C);
      default: coin_val_s = {CRED_W{1'b0}};
    endcase
    // One extra bit so the ceiling compare can never be fooled by wrap-around.
    sum_s    = {1'b0, credit_q} + {1'b0, coin_val_s};
    sel_ok_s = (32'(sel) < NUM_PROD);
    if (sel_ok_s) begin
      price_s = PRICE_LIST[32'(sel)*CRED_W +: CRED_W];
    end else begin
      price_s = {CRED_W{1'b0}};
    end
  end

  // Next-state, credit and output computation.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    bottle_d      = 1'b0;
    prod_id_d     = {SEL_W{1'b0}};
    change_d      = CODE_NONE;
    coin_reject_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // Priority cancel > sel_valid > coin; a coin losing to a winning request is rejected.
        if (cancel && (state_q == ST_COLLECT)) begin
          state_d       = ST_CHANGE;
          coin_reject_d = (in != CODE_NONE);
        end else if (sel_valid && sel_ok_s && (credit_q >= price_s)) begin
          state_d       = ST_VEND;
          credit_d      = credit_q - price_s;
          bottle_d      = 1'b1;
          prod_id_d     = sel;
          coin_reject_d = (in != CODE_NONE);
        end else if (in != CODE_NONE) begin
          if (sum_s <= (CRED_W+1)'(MAX_CREDIT)) begin
            credit_d = sum_s[CRED_W-1:0];
            state_d  = ST_COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_VEND, ST_CHANGE: begin
        // Payback starts in the VEND cycle so the first coin follows the bottle pulse
        // directly. A zero pick value would stall forever, so it also ends payback.
        coin_reject_d = (in != CODE_NONE);
        if ((credit_q != {CRED_W{1'b0}}) && (pick_val_s != {CRED_W{1'b0}})) begin
          change_d = pick_code_s;
          credit_d = credit_q - pick_val_s;
          state_d  = ST_CHANGE;
        end else begin
          credit_d = {CRED_W{1'b0}};
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = {CRED_W{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // State, credit and output registers; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= {CRED_W{1'b0}};
      bottle_q      <= 1'b0;
      prod_id_q     <= {SEL_W{1'b0}};
      change_q      <= CODE_NONE;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      bottle_q      <= bottle_d;
      prod_id_q     <= prod_id_d;
      change_q      <= change_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  assign bottle      = bottle_q;
  assign prod_id     = prod_id_q;
  assign change      = change_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi (default parameters).
// Prices: prod0=10, prod1=15, prod2=20, prod3=25. Coins: 01=5, 10=10, 11=25.
module tb_vending_machine_multi;

  typedef struct {
    logic [1:0] kind;   // 1 = bottle, 2 = change coin, 3 = coin reject
    logic [7:0] val;    // prod_id for bottle, coin code for change, 0 for reject
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in;
  logic [1:0] sel;
  logic       sel_valid;
  logic       cancel;
  logic       bottle;
  logic [1:0] prod_id;
  logic [1:0] change;
  logic       coin_reject;
  logic       busy;
  logic [7:0] credit;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  vending_machine_multi dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .cancel      (cancel),
    .bottle      (bottle),
    .prod_id     (prod_id),
    .change      (change),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic mon_check(input logic [1:0] kind, input logic [7:0] val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none at %0t", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        miscompares++;
        $display("FAIL event: got kind %0d val %0d expected kind %0d val %0d at %0t",
                 kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  // Monitor: every output event seen on the falling edge is matched in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (bottle)          mon_check(2'd1, {6'd0, prod_id});
      if (change != 2'b00) mon_check(2'd2, {6'd0, change});
      if (coin_reject)     mon_check(2'd3, 8'd0);
    end
  end

  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic sv, input logic cn);
    in = c; sel = s; sel_valid = sv; cancel = cn;
    @(posedge clk);
    #1;
    in = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in = 2'b00; sel = 2'd0; sel_valid = 1'b0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bottle", int'(bottle), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy",   int'(busy),   0);
    reset = 1'b0;
    idle(1);

    // Two 10-coins, buy product 2 (price 20): exact payment, no change.
    step(2'b10, 2'd0, 1'b0, 1'b0); chk("t2_credit10", int'(credit), 10);
    step(2'b10, 2'd0, 1'b0, 1'b0); chk("t2_credit20", int'(credit), 20);
    push(2'd1, 8'd2);
    step(2'b00, 2'd2, 1'b1, 1'b0);
    chk("t2_credit_after", int'(credit), 0);
    chk("t2_busy_vend", int'(busy), 1);
    idle(1); chk("t2_idle_busy", int'(busy), 0);
    idle(1);

    // 25 in, buy product 0 (price 10): change 10 then 5 on consecutive cycles.
    step(2'b11, 2'd0, 1'b0, 1'b0); chk("t3_credit25", int'(credit), 25);
    push(2'd1, 8'd0); push(2'd2, 8'd2); push(2'd2, 8'd1);
    step(2'b00, 2'd0, 1'b1, 1'b0); chk("t3_credit15", int'(credit), 15);
    idle(1); chk("t3_credit5", int'(credit), 5);
    idle(1); chk("t3_credit0", int'(credit), 0);
    idle(1); chk("t3_busy_done", int'(busy), 0);

    // 5 in, product 3 (price 25) refused, then cancel refunds one 5-coin.
    step(2'b01, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd3, 1'b1, 1'b0);
    chk("t4_credit_kept", int'(credit), 5);
    chk("t4_not_busy", int'(busy), 0);
    push(2'd2, 8'd1);
    step(2'b00, 2'd0, 1'b0, 1'b1); chk("t4_busy_cancel", int'(busy), 1);
    idle(1); chk("t4_credit0", int'(credit), 0);
    idle(1); chk("t4_idle", int'(busy), 0);

    // Fill to the ceiling, fifth 25 rejected; coin during payback rejected.
    for (int i = 1; i <= 4; i++) begin
      step(2'b11, 2'd0, 1'b0, 1'b0);
      chk("t5_fill", int'(credit), 25 * i);
    end
    push(2'd3, 8'd0);
    step(2'b11, 2'd0, 1'b0, 1'b0); chk("t5_ceiling", int'(credit), 100);
    push(2'd2, 8'd3); push(2'd3, 8'd0); push(2'd2, 8'd3); push(2'd2, 8'd3); push(2'd2, 8'd3);
    step(2'b00, 2'd0, 1'b0, 1'b1);
    step(2'b01, 2'd0, 1'b0, 1'b0); chk("t5_credit75", int'(credit), 75);
    idle(3); chk("t5_credit0", int'(credit), 0);
    idle(1); chk("t5_idle", int'(busy), 0);

    // Coin + sufficient selection together: vend wins, coin rejected.
    step(2'b10, 2'd0, 1'b0, 1'b0);
    push(2'd1, 8'd0); push(2'd3, 8'd0);
    step(2'b10, 2'd0, 1'b1, 1'b0); chk("t6_credit0", int'(credit), 0);
    idle(1);
    // Cancel + selection together: refund wins, no bottle.
    step(2'b11, 2'd0, 1'b0, 1'b0);
    push(2'd2, 8'd3);
    step(2'b00, 2'd0, 1'b1, 1'b1); chk("t6_refund_credit", int'(credit), 25);
    idle(1); chk("t6_credit0b", int'(credit), 0);
    idle(1); chk("t6_idle", int'(busy), 0);

    // Reset in the middle of a refund: everything drops to zero, change is lost.
    step(2'b11, 2'd0, 1'b0, 1'b0);
    step(2'b10, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd0, 1'b0, 1'b1); chk("t1_busy_pre", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t1_busy",   int'(busy),   0);
    chk("t1_credit", int'(credit), 0);
    chk("t1_change", int'(change), 0);
    chk("t1_reject", int'(coin_reject), 0);
    chk("t1_bottle", int'(bottle), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);
    chk("t1_still_idle", int'(busy), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
